// File: rtl/cmp_pkg.sv
// Shared types for the digit-serial integer comparator: operator and FSM
// encodings plus the flag-to-result mapping.
package cmp_pkg;

   typedef enum logic [2:0] {
      OP_LT = 3'd0,
      OP_LE = 3'd1,
      OP_GT = 3'd2,
      OP_GE = 3'd3,
      OP_EQ = 3'd4,
      OP_NE = 3'd5
   } cmp_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } cmp_state_e;

   // Encodings 6 and 7 are reserved and always yield 0.
   function automatic logic op_result(input logic [2:0] op, input logic lt, input logic gt);
      logic eq;
      eq = !lt && !gt;
      case (op)
         OP_LT:   return lt;
         OP_LE:   return lt | eq;
         OP_GT:   return gt;
         OP_GE:   return gt | eq;
         OP_EQ:   return eq;
         OP_NE:   return !eq;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned magnitude compare of one DIGIT-bit slice.
module cmp_digit #(
   parameter int DIGIT = 8
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic             lt,
   output logic             gt
);

   assign lt = (a < b);
   assign gt = (a > b);

endmodule

// File: rtl/cmp_int_serial.sv
// Digit-serial signed/unsigned comparator, MSB digit first, with optional
// early exit on the first differing digit.
module cmp_int_serial
   import cmp_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter int DIGIT      = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             Y
);

   localparam int N  = WIDTH / DIGIT;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   generate
      if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_params
         $error("cmp_int_serial: WIDTH must be a positive multiple of DIGIT");
      end
   endgenerate

   cmp_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [KW-1:0]    k_q, k_d;
   logic             lt_q, lt_d, gt_q, gt_d, y_q, y_d;

   logic dig_lt, dig_gt, lt_n, gt_n, decide;

   // Operands shift left each cycle, so the current digit always sits at the top.
   cmp_digit #(.DIGIT(DIGIT)) u_digit (
      .a  (a_q[WIDTH-1 -: DIGIT]),
      .b  (b_q[WIDTH-1 -: DIGIT]),
      .lt (dig_lt),
      .gt (dig_gt)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      k_d     = k_q;
      lt_d    = lt_q;
      gt_d    = gt_q;
      y_d     = y_q;

      // Flags are sticky: once either is set, later digits are ignored.
      lt_n   = lt_q | (!lt_q && !gt_q && dig_lt);
      gt_n   = gt_q | (!lt_q && !gt_q && dig_gt);
      decide = (k_q == K_LAST) || (EARLY_EXIT && (dig_lt || dig_gt));

      case (state_q)
         ST_SCAN: begin
            lt_d = lt_n;
            gt_d = gt_n;
            a_d  = a_q << DIGIT;
            b_d  = b_q << DIGIT;
            k_d  = k_q + KW'(1);
            if (decide) begin
               state_d = ST_DONE;
               y_d     = op_result(op_q, lt_n, gt_n);
            end
         end
         default: begin
            if (start) begin
               state_d = ST_SCAN;
               // Flipping the sign bits maps two's-complement order onto unsigned order.
               a_d          = A;
               b_d          = B;
               a_d[WIDTH-1] = A[WIDTH-1] ^ is_signed;
               b_d[WIDTH-1] = B[WIDTH-1] ^ is_signed;
               op_d         = op;
               k_d          = '0;
               lt_d         = 1'b0;
               gt_d         = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         k_q     <= '0;
         lt_q    <= 1'b0;
         gt_q    <= 1'b0;
         y_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         k_q     <= k_d;
         lt_q    <= lt_d;
         gt_q    <= gt_d;
         y_q     <= y_d;
      end
   end

   assign busy = (state_q == ST_SCAN);
   assign done = (state_q == ST_DONE);
   assign Y    = y_q;

endmodule

// File: tb/tb_cmp_int_serial.sv
// Directed bench for cmp_int_serial: an early-exit and a constant-time instance
// share operands, each with its own start strobe.
module tb_cmp_int_serial;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start1 = 1'b0, start0 = 1'b0;
   logic [2:0]  op = 3'd0;
   logic        sgn = 1'b0;
   logic [63:0] a = '0, b = '0;
   logic        busy1, done1, y1, busy0, done0, y0;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] MSB_ONE = 64'h8000_0000_0000_0000;
   localparam logic [63:0] PAT     = 64'hDEAD_BEEF_0123_4567;

   always #5 clk = ~clk;

   cmp_int_serial #(.WIDTH(64), .DIGIT(8), .EARLY_EXIT(1'b1)) dut_ee (
      .clk(clk), .rst(rst), .start(start1), .op(op), .is_signed(sgn),
      .A(a), .B(b), .busy(busy1), .done(done1), .Y(y1)
   );

   cmp_int_serial #(.WIDTH(64), .DIGIT(8), .EARLY_EXIT(1'b0)) dut_ct (
      .clk(clk), .rst(rst), .start(start0), .op(op), .is_signed(sgn),
      .A(a), .B(b), .busy(busy0), .done(done0), .Y(y0)
   );

   // Launches one operation and reports done latency (cycles after the
   // accepting edge, -1 on timeout), result, busy cycles and Y stability.
   task automatic run_op(input bit ee, input logic [63:0] av, input logic [63:0] bv,
                         input logic [2:0] o, input logic s,
                         output int lat, output logic y, output int bc, output bit ystable);
      logic yprev;
      int   cyc;
      @(negedge clk);
      yprev   = ee ? y1 : y0;
      a       = av;
      b       = bv;
      op      = o;
      sgn     = s;
      start1  = ee;
      start0  = !ee;
      @(posedge clk);
      #1;
      start1  = 1'b0;
      start0  = 1'b0;
      lat     = -1;
      y       = 1'bx;
      bc      = 0;
      ystable = 1'b1;
      for (cyc = 1; cyc <= 25; cyc++) begin
         if (ee ? done1 : done0) begin
            lat = cyc;
            y   = ee ? y1 : y0;
            break;
         end
         if (ee ? busy1 : busy0) bc++;
         if ((ee ? y1 : y0) !== yprev) ystable = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy1, done1, y1} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ee busy/done/Y got %b want 000", {busy1, done1, y1});
      end
      checks++;
      if ({busy0, done0, y0} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ct busy/done/Y got %b want 000", {busy0, done0, y0});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy1, done1, y1} !== 3'b000) begin
         errors++;
         $display("FAIL idle_after_reset got %b want 000", {busy1, done1, y1});
      end
   endtask

   task automatic test_lt_unsigned();
      int lat, bc; logic y; bit ys;
      run_op(1'b1, 64'd5, 64'd7, 3'd0, 1'b0, lat, y, bc, ys);
      checks++;
      if (lat !== 9 || y !== 1'b1 || !ys) begin
         errors++;
         $display("FAIL lt_5_7 lat=%0d Y=%b stable=%0d want lat=9 Y=1 stable=1", lat, y, ys);
      end
      run_op(1'b1, 64'd5, 64'd7, 3'd3, 1'b0, lat, y, bc, ys);
      checks++;
      if (lat !== 9 || y !== 1'b0 || !ys) begin
         errors++;
         $display("FAIL ge_5_7 lat=%0d Y=%b stable=%0d want lat=9 Y=0 stable=1", lat, y, ys);
      end
   endtask

   task automatic test_msb_early();
      int lat, bc; logic y; bit ys;
      run_op(1'b1, MSB_ONE, 64'd1, 3'd0, 1'b0, lat, y, bc, ys);
      checks++;
      if (lat !== 2 || y !== 1'b0) begin
         errors++;
         $display("FAIL msb_lt_unsigned lat=%0d Y=%b want lat=2 Y=0", lat, y);
      end
      run_op(1'b1, MSB_ONE, 64'd1, 3'd0, 1'b1, lat, y, bc, ys);
      checks++;
      if (lat !== 2 || y !== 1'b1 || !ys) begin
         errors++;
         $display("FAIL msb_lt_signed lat=%0d Y=%b stable=%0d want lat=2 Y=1 stable=1", lat, y, ys);
      end
   endtask

   task automatic test_equal();
      logic [2:0] ops [5] = '{3'd4, 3'd5, 3'd1, 3'd2, 3'd7};
      logic       exp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      int lat, bc; logic y; bit ys;
      for (int i = 0; i < 5; i++) begin
         run_op(1'b1, PAT, PAT, ops[i], 1'b0, lat, y, bc, ys);
         checks++;
         if (lat !== 9 || y !== exp[i]) begin
            errors++;
            $display("FAIL equal_op%0d lat=%0d Y=%b want lat=9 Y=%b", ops[i], lat, y, exp[i]);
         end
      end
   endtask

   task automatic test_constant_time();
      int lat, bc; logic y; bit ys;
      run_op(1'b0, MSB_ONE, 64'd1, 3'd0, 1'b0, lat, y, bc, ys);
      checks++;
      if (lat !== 9 || y !== 1'b0 || bc !== 8) begin
         errors++;
         $display("FAIL ct_unsigned lat=%0d Y=%b busy=%0d want lat=9 Y=0 busy=8", lat, y, bc);
      end
      run_op(1'b0, MSB_ONE, 64'd1, 3'd0, 1'b1, lat, y, bc, ys);
      checks++;
      if (lat !== 9 || y !== 1'b1 || bc !== 8 || !ys) begin
         errors++;
         $display("FAIL ct_signed lat=%0d Y=%b busy=%0d stable=%0d want lat=9 Y=1 busy=8 stable=1",
                  lat, y, bc, ys);
      end
   endtask

   task automatic test_back_to_back();
      int  cyc;
      bit  seen;
      @(negedge clk);
      a = 64'd5; b = 64'd7; op = 3'd0; sgn = 1'b0; start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      seen   = 1'b0;
      for (cyc = 1; cyc <= 20; cyc++) begin
         if (done1) begin
            seen = 1'b1;
            break;
         end
         // A start while scanning, with operands that would flip the answer.
         if (cyc == 3) begin
            start1 = 1'b1; a = 64'd9;
         end else begin
            start1 = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (!seen || cyc !== 9 || y1 !== 1'b1) begin
         errors++;
         $display("FAIL ignore_start seen=%0d lat=%0d Y=%b want lat=9 Y=1", seen, cyc, y1);
      end
      // Start in the done cycle.
      a = MSB_ONE; b = 64'd1; op = 3'd0; sgn = 1'b0; start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0 || y1 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_scan busy=%b done=%b Y=%b want 1 0 1", busy1, done1, y1);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done1 !== 1'b1 || y1 !== 1'b0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done done=%b Y=%b busy=%b want 1 0 0", done1, y1, busy1);
      end
   endtask

   task automatic test_mid_reset();
      int lat, bc, dcount; logic y; bit ys;
      run_op(1'b1, 64'd5, 64'd7, 3'd0, 1'b0, lat, y, bc, ys);
      checks++;
      if (lat !== 9 || y !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_op lat=%0d Y=%b want lat=9 Y=1", lat, y);
      end
      @(negedge clk);
      a = 64'd5; b = 64'd7; op = 3'd3; start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({busy1, done1, y1} !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset busy/done/Y got %b want 000", {busy1, done1, y1});
      end
      @(negedge clk);
      rst    = 1'b0;
      dcount = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (done1) dcount++;
      end
      checks++;
      if (dcount !== 0) begin
         errors++;
         $display("FAIL no_done_after_reset got %0d done pulses want 0", dcount);
      end
      run_op(1'b1, 64'd5, 64'd7, 3'd0, 1'b0, lat, y, bc, ys);
      checks++;
      if (lat !== 9 || y !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_op lat=%0d Y=%b want lat=9 Y=1", lat, y);
      end
   endtask

   initial begin
      test_reset();
      test_lt_unsigned();
      test_msb_early();
      test_equal();
      test_constant_time();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
